// File: rtl/mips_mc_if.sv
// mips_mc_if: status/trace outputs of the mips_mc core plus the instruction-memory load port.
// master = core side, slave = system/bench side.
interface mips_mc_if #(
    parameter int IM_AW = 10
);
    logic [31:0]      pc_o;
    logic [2:0]       state_o;
    logic             retire_o;
    logic             rf_we_o;
    logic [4:0]       rf_wa_o;
    logic [31:0]      rf_wd_o;
    logic             illegal_o;

    logic             im_we;
    logic [IM_AW-1:0] im_wa;
    logic [31:0]      im_wd;

    modport master (
        output pc_o, state_o, retire_o, rf_we_o, rf_wa_o, rf_wd_o, illegal_o,
        input  im_we, im_wa, im_wd
    );

    modport slave (
        input  pc_o, state_o, retire_o, rf_we_o, rf_wa_o, rf_wd_o, illegal_o,
        output im_we, im_wa, im_wd
    );
endinterface

// File: rtl/mips_mc.sv
// mips_mc: multi-cycle MIPS-lite core (FETCH/DECODE/EXEC/MEM/WB) with GPR file, ALU,
// extender and both memories. IM contents are written through the interface load port.
// Optional feature macro: MIPS_OVF_TRAP_EN (signed-overflowing addi writes $30 <= 1 instead of rt).
module mips_mc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_AW    = 10,
    parameter int          DM_AW    = 10
) (
    input logic       clk,
    input logic       rst,
    mips_mc_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_ADDI = 6'h08,
                           OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02,
                           OP_JAL = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;

    state_t      state, state_nx;
    logic [31:0] pc, ir, a, b, alu_out, mdr, alu_res;
    logic [31:0] gpr [32];
    logic [31:0] im  [2**IM_AW];
    logic [31:0] dm  [2**DM_AW];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] sext_imm, zext_imm;
    logic        is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui, is_addi;
    logic        is_lw, is_sw, is_beq, is_j, is_jal, legal;

    logic        retire, illegal, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign fn       = ir[5:0];
    assign imm      = ir[15:0];
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'h0000, imm};

    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (fn == FN_ADDU);
    assign is_subu  = is_rtype && (fn == FN_SUBU);
    assign is_jr    = is_rtype && (fn == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign legal    = is_addu | is_subu | is_jr | is_ori | is_lui | is_addi |
                      is_lw | is_sw | is_beq | is_j | is_jal;

`ifdef MIPS_OVF_TRAP_EN
    logic addi_ovf;
    // A is still the addi source in WB, so overflow is recovered from A, imm and the sum.
    assign addi_ovf = is_addi && (a[31] == sext_imm[31]) && (alu_out[31] != a[31]);
`endif

    // ALU: operation selected by the decoded instruction; address/addi sum is the fallback.
    always_comb begin
        alu_res = a + sext_imm;
        if (is_addu)      alu_res = a + b;
        else if (is_subu) alu_res = a - b;
        else if (is_ori)  alu_res = a | zext_imm;
        else if (is_lui)  alu_res = {imm, 16'h0000};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    // Next-state decode plus retire/illegal pulses and GPR write strobe.
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        illegal  = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_wd    = '0;
        case (state)
            FETCH: state_nx = DECODE;
            DECODE: begin
                if (!legal) begin
                    illegal  = 1'b1;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else if (is_j || is_jal) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                    if (is_jal) begin
                        rf_we = 1'b1;
                        rf_wa = 5'd31;
                        rf_wd = pc;
                    end
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    state_nx = MEM;
                end else if (is_beq || is_jr) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                if (is_sw) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = WB;
                end
            end
            WB: begin
                retire   = 1'b1;
                rf_we    = 1'b1;
                rf_wa    = is_rtype ? rd : rt;
                rf_wd    = is_lw ? mdr : alu_out;
`ifdef MIPS_OVF_TRAP_EN
                if (addi_ovf) begin
                    rf_wa = 5'd30;
                    rf_wd = 32'd1;
                end
`endif
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    // Datapath registers, PC and GPR file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= PC_RESET;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            if (rf_we && (rf_wa != 5'd0)) gpr[rf_wa] <= rf_wd;
            case (state)
                FETCH: begin
                    ir <= im[pc[IM_AW+1:2]];
                    pc <= pc + 32'd4;
                end
                DECODE: begin
                    a       <= gpr[rs];
                    b       <= gpr[rt];
                    alu_out <= pc + {sext_imm[29:0], 2'b00};
                    if (is_j || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                EXEC: begin
                    if (is_beq) begin
                        if (a == b) pc <= alu_out;
                    end else if (is_jr) begin
                        pc <= a;
                    end else begin
                        alu_out <= alu_res;
                    end
                end
                MEM: if (is_lw) mdr <= dm[alu_out[DM_AW+1:2]];
                default: ;
            endcase
        end
    end

    // Data memory store; gated by rst so a reset edge never completes a pending sw.
    always_ff @(posedge clk) begin
        if (rst && (state == MEM) && is_sw) dm[alu_out[DM_AW+1:2]] <= b;
    end

    // Instruction memory load port.
    always_ff @(posedge clk) begin
        if (bus.im_we) im[bus.im_wa] <= bus.im_wd;
    end

    assign bus.pc_o      = pc;
    assign bus.state_o   = state;
    assign bus.retire_o  = retire;
    assign bus.illegal_o = illegal;
    assign bus.rf_we_o   = rf_we;
    assign bus.rf_wa_o   = rf_wa;
    assign bus.rf_wd_o   = rf_wd;
endmodule
